// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, line idle level and
// parameter sanity helper used by the transmitter and the planned receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } tx_state_e;

  localparam logic TX_IDLE_LEVEL = 1'b1;

  // The baud counter needs at least one bit of width.
  function automatic bit clks_per_bit_ok(input int unsigned clks_per_bit);
    return clks_per_bit >= 2;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each bit with tick; clear restarts the period from 0.
module uart_baud_counter #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_drain.sv
// Pops bytes from a registered-output FIFO and serialises each one onto a
// UART line (start, LSB-first data, optional even parity, stop bits).
module uart_tx_drain
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned PARITY_EN    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_rd,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned BW = $clog2(DATA_WIDTH) + 1;
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  if (!clks_per_bit_ok(CLKS_PER_BIT)) begin : g_cpb_check
    $error("uart_tx_drain: CLKS_PER_BIT must be >= 2");
  end

  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  parity_q, parity_d;
  logic [BW-1:0]         bit_idx_q, bit_idx_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  tick;
  logic                  baud_clear;

  // Every state change restarts the bit period so each state owns whole bits.
  assign baud_clear = (state_d != state_q);

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(baud_clear),
    .tick (tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    bit_idx_d = bit_idx_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable && !fifo_empty) state_d = FETCH;
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        shift_d   = fifo_rdata;
        parity_d  = (PARITY_EN != 0) ? ^fifo_rdata : 1'b0;
        bit_idx_d = '0;
        state_d   = START;
      end
      START: begin
        if (tick) state_d = DATA;
      end
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == LAST_DATA) begin
            bit_idx_d = '0;
            state_d   = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (tick) state_d = STOP;
      end
      STOP: begin
        if (tick) begin
          if (bit_idx_q == LAST_STOP) begin
            bit_idx_d = '0;
            done_d    = 1'b1;
            state_d   = IDLE;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level is decoded from the next state so tx stays aligned with state_q.
  always_comb begin
    busy_d = (state_d != IDLE);
    case (state_d)
      START:   tx_d = ~TX_IDLE_LEVEL;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = parity_d;
      default: tx_d = TX_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      bit_idx_q <= '0;
      tx_q      <= TX_IDLE_LEVEL;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign fifo_rd    = (state_q == FETCH);
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: doc/uart_tx_drain.md
Name: uart_tx_drain

Overview:
- Drains bytes from the upstream `fifo` (`rd`/`empty`/`rdata` side) and serialises each one onto a single UART line (8N1 by default).
- Sits directly downstream of the FIFO and is its only reader.
- The FIFO's `rdata` is registered: it becomes valid one cycle after `rd` is sampled with `!empty`. This block's fetch sequence is timed around that latency.

Parameters:
- DATA_WIDTH, 8: bits per frame; must match the FIFO's DATA_WIDTH.
- CLKS_PER_BIT, 16: clk cycles per UART bit; must be ≥2.
- STOP_BITS, 1: number of stop bits (1 or 2).
- PARITY_EN, 0: 1 inserts an even-parity bit after the data bits.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  permits starting a new frame.
- fifo_empty  in  1  FIFO `empty` flag.
- fifo_rdata  in  DATA_WIDTH  FIFO `rdata`.
- fifo_rd  out  1  FIFO `rd` strobe.
- tx  out  1  serial line, idles high.
- busy  out  1  high from FETCH through the end of STOP.
- frame_done  out  1  one-cycle pulse after the last stop-bit cycle.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, tx=1, busy=0, fifo_rd=0, frame_done=0.
  - Shift register, baud counter and bit index all cleared.
  - The effect is immediate, not clock-aligned.
- Outputs:
  - tx, busy and frame_done are registered.
  - fifo_rd is decoded from state only (high only in FETCH), so it is never high during reset.
- State machine IDLE → FETCH → LOAD → START → DATA → [PARITY] → STOP → IDLE:
  - IDLE: tx=1. If enable && !fifo_empty, go to FETCH; otherwise stay.
  - FETCH: exactly one cycle. fifo_rd=1. The FIFO registers rdata at the end of this cycle.
  - LOAD: one cycle. Capture fifo_rdata into the shift register. If PARITY_EN, compute the parity bit as the XOR of all data bits. Go to START.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: send DATA_WIDTH bits, LSB first, each for CLKS_PER_BIT cycles. Shift right at each bit boundary.
  - PARITY: present only if PARITY_EN. tx=parity bit for CLKS_PER_BIT cycles.
  - STOP: tx=1 for CLKS_PER_BIT*STOP_BITS cycles. On the last cycle, set frame_done=1 for the following cycle and go to IDLE.
- Baud counter:
  - Width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1.
  - Reloads to 0 on every state change.
  - A bit boundary is when the counter equals CLKS_PER_BIT-1.
- Bit index: width $clog2(DATA_WIDTH)+1. No wrap-around within a frame.
- Frame length: 1+DATA_WIDTH+PARITY_EN+STOP_BITS bit-times, with tx continuous over that span.
- Back-to-back frames: the tx-high gap between consecutive frames is exactly 3 cycles (IDLE, FETCH, LOAD).
- Empty handling:
  - fifo_rd is never issued while fifo_empty was high in the deciding IDLE cycle.
  - As sole reader, emptiness cannot appear between IDLE and FETCH.
- enable low mid-frame: the current frame completes; no further fetch is issued.
- fifo_empty or fifo_rdata changing after LOAD: no effect on the frame in flight.
- Reset mid-frame: the frame is aborted and tx goes high immediately. The byte already popped is lost; no re-read is attempted.

Decomposition:
- Shared package/header `uart_pkg`:
  - state encodings (IDLE=0, FETCH=1, LOAD=2, START=3, DATA=4, PARITY=5, STOP=6; 3-bit);
  - TX_IDLE_LEVEL=1;
  - the CLKS_PER_BIT≥2 constraint check.
- Natural sub-module `uart_baud_counter`:
  - inputs: clk, rst_n, clear;
  - output: a `tick` at each bit boundary;
  - parameter: CLKS_PER_BIT.
  - It will be reused by the planned receiver.

Test Plan:
All scenarios use CLKS_PER_BIT=4, DATA_WIDTH=8 unless stated.
1. rst_n=0 with FIFO non-empty → tx=1, busy=0, fifo_rd=0 throughout reset. No read is issued until after rst_n rises.
2. Push 0xA5, enable=1:
   - fifo_rd is a single 1-cycle pulse 1 cycle after fifo_empty falls.
   - tx sequence: low 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then high 4 cycles.
   - 40 tx cycles total, then one frame_done pulse.
3. Push 0x00 then 0xFF → two fifo_rd pulses, two frames, exactly 3 tx-high cycles between the stop of frame 1 and the start of frame 2. FIFO ends empty.
4. enable held 0 with 3 bytes queued → no fifo_rd and tx=1. Then set enable=1 and drop it during frame 1's DATA → frame 1 completes, and exactly 1 read has occurred.
5. PARITY_EN=1, STOP_BITS=2, byte 0x07 → parity bit=1, stop held 8 cycles, 48 tx cycles total.
6. Queue 0x3C, 0x81; assert rst_n=0 during DATA bit 3 of 0x3C:
   - tx=1 and busy=0 asynchronously.
   - After release, the next frame carries 0x81.
